// File: rtl/pipelined_control_unit.sv
// Main decoder, ALU decoder and D->E->M->W control pipeline for a five-stage RISC-V core.
// Optional macro PCU_BRANCH_EXT_EN adds bne/blt/bge/bltu/bgeu resolution in Execute.
module pipelined_control_unit #(
    parameter int ALUCTRL_W = 3,
    parameter int RESSRC_W  = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [6:0]           opD,
    input  logic [2:0]           funct3D,
    input  logic                 funct7b5D,
    input  logic                 FlushE,
    input  logic                 ZeroE,
    input  logic                 LtE,
    input  logic                 LtuE,
    output logic [1:0]           ImmSrcD,
    output logic                 IllegalD,
    output logic [ALUCTRL_W-1:0] ALUControlE,
    output logic                 ALUSrcE,
    output logic                 PCSrcE,
    output logic [RESSRC_W-1:0]  ResultSrcE,
    output logic                 RegWriteM,
    output logic                 MemWriteM,
    output logic [RESSRC_W-1:0]  ResultSrcM,
    output logic                 RegWriteW,
    output logic [RESSRC_W-1:0]  ResultSrcW
);

    typedef enum logic [6:0] {
        OP_LOAD   = 7'b0000011,
        OP_STORE  = 7'b0100011,
        OP_RTYPE  = 7'b0110011,
        OP_BRANCH = 7'b1100011,
        OP_IALU   = 7'b0010011,
        OP_JAL    = 7'b1101111
    } opcode_e;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_e;

    typedef struct packed {
        logic                 regwrite;
        logic [RESSRC_W-1:0]  resultsrc;
        logic                 memwrite;
        logic                 jump;
        logic                 branch;
        logic [ALUCTRL_W-1:0] aluctrl;
        logic                 alusrc;
    } e_ctrl_t;

    typedef struct packed {
        logic                regwrite;
        logic [RESSRC_W-1:0] resultsrc;
        logic                memwrite;
    } m_ctrl_t;

    typedef struct packed {
        logic                regwrite;
        logic [RESSRC_W-1:0] resultsrc;
    } w_ctrl_t;

    e_ctrl_t e_d, e_q;
    m_ctrl_t m_q;
    w_ctrl_t w_q;
    aluop_e  alu_op;
    logic [1:0] res_src;
    logic [2:0] alu_code;
    logic       taken_e;

    // Main decoder: unlisted opcodes leave every control at zero, so they travel as bubbles.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        ImmSrcD     = 2'b00;
        IllegalD    = 1'b0;
        alu_op      = ALUOP_ADD;
        res_src     = 2'b00;
        e_d         = '0;
        case (opD)
            OP_LOAD:   begin e_d.regwrite = 1'b1; e_d.alusrc = 1'b1; res_src = 2'b01; end
            OP_STORE:  begin ImmSrcD = 2'b01; e_d.alusrc = 1'b1; e_d.memwrite = 1'b1; end
            OP_RTYPE:  begin e_d.regwrite = 1'b1; alu_op = ALUOP_FUNCT; end
            OP_BRANCH: begin ImmSrcD = 2'b10; e_d.branch = 1'b1; alu_op = ALUOP_SUB; end
            OP_IALU:   begin e_d.regwrite = 1'b1; e_d.alusrc = 1'b1; alu_op = ALUOP_FUNCT; end
            OP_JAL:    begin e_d.regwrite = 1'b1; ImmSrcD = 2'b11; res_src = 2'b10; e_d.jump = 1'b1; end
            default:   IllegalD = 1'b1;
        endcase
        e_d.resultsrc = RESSRC_W'(res_src);
    end

    always_comb begin
        alu_code = 3'b000;
        case (alu_op)
            ALUOP_SUB: alu_code = 3'b001;
            ALUOP_FUNCT: begin
                case (funct3D)
                    3'b000:  alu_code = (funct7b5D & opD[5]) ? 3'b001 : 3'b000;
                    3'b010:  alu_code = 3'b101;
                    3'b110:  alu_code = 3'b011;
                    3'b111:  alu_code = 3'b010;
                    default: alu_code = 3'b000;
                endcase
            end
            default: alu_code = 3'b000;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
        if (reset) begin
            e_q <= '0;
            m_q <= '0;
            w_q <= '0;
        end else begin
            e_q <= FlushE ? '0 : {e_d[$bits(e_ctrl_t)-1:ALUCTRL_W+1], ALUCTRL_W'(alu_code), e_d.alusrc};
            m_q <= '{regwrite: e_q.regwrite, resultsrc: e_q.resultsrc, memwrite: e_q.memwrite};
            w_q <= '{regwrite: m_q.regwrite, resultsrc: m_q.resultsrc};
        end
    end

`ifdef PCU_BRANCH_EXT_EN
    logic [2:0] funct3_e_q;

    always_ff @(posedge clk) begin
        if (reset || FlushE) funct3_e_q <= 3'b000;
        else                 funct3_e_q <= funct3D;
    end

    always_comb begin
        taken_e = 1'b0;
        case (funct3_e_q)
            3'b000:  taken_e = ZeroE;
            3'b001:  taken_e = ~ZeroE;
            3'b100:  taken_e = LtE;
            3'b101:  taken_e = ~LtE;
            3'b110:  taken_e = LtuE;
            3'b111:  taken_e = ~LtuE;
            default: taken_e = 1'b0;
        endcase
    end
`else
    // beq-only build: the magnitude flags are accepted but ignored.
    logic unused_flags;
    assign unused_flags = LtE ^ LtuE;
    assign taken_e      = ZeroE;
`endif

    assign ALUControlE = e_q.aluctrl;
    assign ALUSrcE     = e_q.alusrc;
    assign ResultSrcE  = e_q.resultsrc;
    assign PCSrcE      = (e_q.branch & taken_e) | e_q.jump;
    assign RegWriteM   = m_q.regwrite;
    assign MemWriteM   = m_q.memwrite;
    assign ResultSrcM  = m_q.resultsrc;
    assign RegWriteW   = w_q.regwrite;
    assign ResultSrcW  = w_q.resultsrc;

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Self-checking bench for pipelined_control_unit: directed scenarios plus randomized
// instruction streams scored against a table-driven reference of the decode rules.
module tb_pipelined_control_unit;

    localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
    localparam logic [6:0] BR = 7'b1100011, IA = 7'b0010011, JAL = 7'b1101111;
    localparam logic [6:0] BUB = 7'b0000000;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [6:0] opD = 7'd0;
    logic [2:0] funct3D = 3'd0;
    logic       funct7b5D = 1'b0, FlushE = 1'b0;
    logic       ZeroE = 1'b0, LtE = 1'b0, LtuE = 1'b0;
    logic [1:0] ImmSrcD;
    logic       IllegalD;
    logic [2:0] ALUControlE;
    logic       ALUSrcE, PCSrcE;
    logic [1:0] ResultSrcE, ResultSrcM, ResultSrcW;
    logic       RegWriteM, MemWriteM, RegWriteW;

    int vectors = 0;
    int miscompares = 0;

    pipelined_control_unit #(.ALUCTRL_W(3), .RESSRC_W(2)) dut (
        .clk(clk), .reset(reset), .opD(opD), .funct3D(funct3D), .funct7b5D(funct7b5D),
        .FlushE(FlushE), .ZeroE(ZeroE), .LtE(LtE), .LtuE(LtuE),
        .ImmSrcD(ImmSrcD), .IllegalD(IllegalD), .ALUControlE(ALUControlE), .ALUSrcE(ALUSrcE),
        .PCSrcE(PCSrcE), .ResultSrcE(ResultSrcE), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM),
        .ResultSrcM(ResultSrcM), .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        bit       rw;
        bit [1:0] imm;
        bit       alusrc;
        bit       mw;
        bit [1:0] rs;
        bit       br;
        bit       jmp;
        bit [2:0] alu;
        bit       ill;
    } dec_t;

    // Reference pipeline contents, expressed per stage as the instruction's meaning.
    dec_t     e_m = '0;
    bit [2:0] e_f3 = 3'd0;
    bit       m_rw = 0, m_mw = 0, w_rw = 0;
    bit [1:0] m_rs = 0, w_rs = 0;

    function automatic dec_t ref_decode(bit [6:0] op, bit [2:0] f3, bit f7);
        dec_t c = '0;
        bit by_funct = 0;
        case (op)
            LW:  begin c.rw = 1; c.alusrc = 1; c.rs = 2'b01; end
            SW:  begin c.imm = 2'b01; c.alusrc = 1; c.mw = 1; end
            RT:  begin c.rw = 1; by_funct = 1; end
            BR:  begin c.imm = 2'b10; c.br = 1; c.alu = 3'b001; end
            IA:  begin c.rw = 1; c.alusrc = 1; by_funct = 1; end
            JAL: begin c.rw = 1; c.imm = 2'b11; c.rs = 2'b10; c.jmp = 1; end
            default: c.ill = 1;
        endcase
        if (by_funct) begin
            case (f3)
                3'b000:  c.alu = (f7 && op == RT) ? 3'b001 : 3'b000;
                3'b010:  c.alu = 3'b101;
                3'b110:  c.alu = 3'b011;
                3'b111:  c.alu = 3'b010;
                default: c.alu = 3'b000;
            endcase
        end
        return c;
    endfunction

    function automatic bit ref_taken(bit [2:0] f3, bit z, bit lt, bit ltu);
`ifdef PCU_BRANCH_EXT_EN
        case (f3)
            3'b000:  return z;
            3'b001:  return !z;
            3'b100:  return lt;
            3'b101:  return !lt;
            3'b110:  return ltu;
            3'b111:  return !ltu;
            default: return 0;
        endcase
`else
        return z;
`endif
    endfunction

    function automatic logic [12:0] exp_pipe();
        return {e_m.alu, e_m.alusrc, e_m.rs, m_rw, m_mw, m_rs, w_rw, w_rs};
    endfunction

    function automatic logic exp_pcsrc();
        return (e_m.br & ref_taken(e_f3, ZeroE, LtE, LtuE)) | e_m.jmp;
    endfunction

    // Drive one instruction into Decode, clock it, advance the reference, settle.
    task automatic step(input bit [6:0] op, input bit [2:0] f3, input bit f7,
                        input bit flush, input bit rst);
        dec_t d;
        @(negedge clk);
        opD = op; funct3D = f3; funct7b5D = f7; FlushE = flush; reset = rst;
        @(posedge clk);
        d = ref_decode(op, f3, f7);
        if (rst) begin
            e_m = '0; e_f3 = 0; m_rw = 0; m_mw = 0; m_rs = 0; w_rw = 0; w_rs = 0;
        end else begin
            w_rw = m_rw; w_rs = m_rs;
            m_rw = e_m.rw; m_mw = e_m.mw; m_rs = e_m.rs;
            if (flush) begin e_m = '0; e_f3 = 0; end
            else begin e_m = d; e_f3 = f3; end
        end
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1; opD = 7'b1111111; #1;
        vectors++;
        if (IllegalD !== 1'b1 || ImmSrcD !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_comb_illegal: got ill=%0b imm=%b want ill=1 imm=00", IllegalD, ImmSrcD);
        end
        opD = JAL; #1;
        vectors++;
        if (IllegalD !== 1'b0 || ImmSrcD !== 2'b11) begin
            miscompares++;
            $display("FAIL reset_comb_jal: got ill=%0b imm=%b want ill=0 imm=11", IllegalD, ImmSrcD);
        end
        step(JAL, 3'd0, 0, 1, 1);
        step(LW, 3'd0, 0, 0, 1);
        vectors++;
        if ({ALUControlE, ALUSrcE, ResultSrcE, RegWriteM, MemWriteM, ResultSrcM, RegWriteW, ResultSrcW, PCSrcE} !== 14'd0) begin
            miscompares++;
            $display("FAIL reset_state: got %b want all zero",
                     {ALUControlE, ALUSrcE, ResultSrcE, RegWriteM, MemWriteM, ResultSrcM, RegWriteW, ResultSrcW, PCSrcE});
        end
    endtask

    task automatic test_lw_latency();
        step(BUB, 0, 0, 0, 1);
        step(LW, 3'b010, 0, 0, 0);
        vectors++;
        if (ResultSrcE !== 2'b01 || ALUSrcE !== 1'b1) begin
            miscompares++;
            $display("FAIL lw_E: got rs=%b alusrc=%0b want rs=01 alusrc=1", ResultSrcE, ALUSrcE);
        end
        step(BUB, 0, 0, 0, 0);
        vectors++;
        if (RegWriteM !== 1'b1 || MemWriteM !== 1'b0) begin
            miscompares++;
            $display("FAIL lw_M: got rw=%0b mw=%0b want rw=1 mw=0", RegWriteM, MemWriteM);
        end
        step(BUB, 0, 0, 0, 0);
        vectors++;
        if (RegWriteW !== 1'b1 || ResultSrcW !== 2'b01) begin
            miscompares++;
            $display("FAIL lw_W: got rw=%0b rs=%b want rw=1 rs=01", RegWriteW, ResultSrcW);
        end
    endtask

    task automatic test_alu_decode();
        step(RT, 3'b000, 1, 0, 0);
        vectors++;
        if (ALUControlE !== 3'b001) begin
            miscompares++;
            $display("FAIL alu_sub_r: got %b want 001", ALUControlE);
        end
        step(IA, 3'b000, 1, 0, 0);
        vectors++;
        if (ALUControlE !== 3'b000) begin
            miscompares++;
            $display("FAIL alu_addi_f7: got %b want 000", ALUControlE);
        end
        for (int f = 0; f < 8; f++) begin
            step(RT, 3'(f), 0, 0, 0);
            vectors++;
            if (ALUControlE !== e_m.alu) begin
                miscompares++;
                $display("FAIL alu_funct3_%0d: got %b want %b", f, ALUControlE, e_m.alu);
            end
        end
    endtask

    task automatic test_flush();
        step(SW, 3'b010, 0, 0, 0);
        step(BUB, 0, 0, 0, 0);
        vectors++;
        if (MemWriteM !== 1'b1) begin
            miscompares++;
            $display("FAIL sw_M: got mw=%0b want 1", MemWriteM);
        end
        step(SW, 3'b010, 0, 1, 0);
        vectors++;
        if (ALUSrcE !== 1'b0 || PCSrcE !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_E: got alusrc=%0b pcsrc=%0b want 0 0", ALUSrcE, PCSrcE);
        end
        step(BUB, 0, 0, 0, 0);
        vectors++;
        if (MemWriteM !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_M: got mw=%0b want 0", MemWriteM);
        end
        step(BUB, 0, 0, 1, 1);
        vectors++;
        if ({ALUSrcE, RegWriteM, RegWriteW} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_flush: got %b want 000", {ALUSrcE, RegWriteM, RegWriteW});
        end
    endtask

    task automatic test_branch();
        logic want_z0, want_z1;
`ifdef PCU_BRANCH_EXT_EN
        want_z0 = 1'b1; want_z1 = 1'b0;
`else
        want_z0 = 1'b0; want_z1 = 1'b1;
`endif
        step(BR, 3'b001, 0, 0, 0);
        vectors++;
        if (ALUControlE !== 3'b001) begin
            miscompares++;
            $display("FAIL br_alu: got %b want 001", ALUControlE);
        end
        ZeroE = 0; #1;
        vectors++;
        if (PCSrcE !== want_z0) begin
            miscompares++;
            $display("FAIL bne_zero0: got %0b want %0b", PCSrcE, want_z0);
        end
        ZeroE = 1; #1;
        vectors++;
        if (PCSrcE !== want_z1) begin
            miscompares++;
            $display("FAIL bne_zero1: got %0b want %0b", PCSrcE, want_z1);
        end
        ZeroE = 0;
    endtask

    task automatic test_jal_reset_illegal();
        step(JAL, 0, 0, 0, 0);
        vectors++;
        if (PCSrcE !== 1'b1 || ResultSrcE !== 2'b10) begin
            miscompares++;
            $display("FAIL jal_E: got pcsrc=%0b rs=%b want 1 10", PCSrcE, ResultSrcE);
        end
        step(BUB, 0, 0, 0, 0);
        vectors++;
        if (RegWriteM !== 1'b1) begin
            miscompares++;
            $display("FAIL jal_M: got rw=%0b want 1", RegWriteM);
        end
        step(BUB, 0, 0, 0, 1);
        vectors++;
        if (RegWriteW !== 1'b0) begin
            miscompares++;
            $display("FAIL jal_reset_W: got rw=%0b want 0", RegWriteW);
        end
        step(7'b1111111, 3'b111, 1, 0, 0);
        vectors++;
        if (IllegalD !== 1'b1 || PCSrcE !== 1'b0 || ALUSrcE !== 1'b0) begin
            miscompares++;
            $display("FAIL illegal_E: got ill=%0b pcsrc=%0b alusrc=%0b want 1 0 0", IllegalD, PCSrcE, ALUSrcE);
        end
        step(BUB, 0, 0, 0, 0);
        step(BUB, 0, 0, 0, 0);
        vectors++;
        if ({RegWriteM, MemWriteM, RegWriteW} !== 3'b000) begin
            miscompares++;
            $display("FAIL illegal_writes: got %b want 000", {RegWriteM, MemWriteM, RegWriteW});
        end
    endtask

    task automatic test_random();
        logic [6:0] ops [6] = '{LW, SW, RT, BR, IA, JAL};
        logic [6:0] op;
        dec_t d;
        for (int n = 0; n < 400; n++) begin
            op = ($urandom_range(0, 4) == 0) ? 7'($urandom) : ops[$urandom_range(0, 5)];
            step(op, 3'($urandom), 1'($urandom), $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0);
            ZeroE = 1'($urandom); LtE = 1'($urandom); LtuE = 1'($urandom);
            #1;
            d = ref_decode(op, funct3D, funct7b5D);
            vectors++;
            if ({ALUControlE, ALUSrcE, ResultSrcE, RegWriteM, MemWriteM, ResultSrcM, RegWriteW, ResultSrcW} !== exp_pipe()
                || PCSrcE !== exp_pcsrc()) begin
                miscompares++;
                $display("FAIL rand_pipe_%0d: got %b pc=%0b want %b pc=%0b", n,
                         {ALUControlE, ALUSrcE, ResultSrcE, RegWriteM, MemWriteM, ResultSrcM, RegWriteW, ResultSrcW},
                         PCSrcE, exp_pipe(), exp_pcsrc());
            end
            vectors++;
            if (IllegalD !== d.ill || (op != RT && ImmSrcD !== d.imm)) begin
                miscompares++;
                $display("FAIL rand_decode_%0d: op=%b got ill=%0b imm=%b want ill=%0b imm=%b",
                         n, op, IllegalD, ImmSrcD, d.ill, d.imm);
            end
        end
    endtask

    initial begin
        test_reset();
        test_lw_latency();
        test_alu_decode();
        test_flush();
        test_branch();
        test_jal_reset_illegal();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
